axonerve_kvs_cmd_arbiter: RTL and testbench

//  Shares one axonerve_kvs_kernel command port between NUM_REQ requesters. Round-robin

---
 rtl/axonerve_kvs_cmd_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axonerve_kvs_cmd_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axonerve_kvs_cmd_arbiter.sv
// Round-robin arbiter that shares one axonerve_kvs_kernel command port
// between NUM_REQ requesters. Each issued command is tagged with its
// requester ID; kernel ACKs are returned to the owner in issue order.
// Reads, illegal ops and writes into a full entry table are answered
// locally with ENT_ERR without reaching the kernel.
module axonerve_kvs_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_OUT     = 16,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                          I_CLK,
    input  logic                          I_XRST,
    input  logic [NUM_REQ-1:0]            I_REQ_VALID,
    input  logic [3*NUM_REQ-1:0]          I_REQ_OP,
    input  logic [128*NUM_REQ-1:0]        I_REQ_KEY_DAT,
    input  logic [128*NUM_REQ-1:0]        I_REQ_EKEY_MSK,
    input  logic [7*NUM_REQ-1:0]          I_REQ_KEY_PRI,
    input  logic [32*NUM_REQ-1:0]         I_REQ_KEY_VALUE,
    output logic [NUM_REQ-1:0]            O_REQ_GRANT,
    output logic [NUM_REQ-1:0]            O_RSP_VALID,
    output logic                          O_RSP_ENT_ERR,
    output logic                          O_RSP_SINGLE_HIT,
    output logic                          O_RSP_MULTI_HIT,
    output logic [31:0]                   O_RSP_KEY_VALUE,
    output logic                          O_KVS_CMD_VALID,
    output logic                          O_KVS_CMD_ERASE,
    output logic                          O_KVS_CMD_WRITE,
    output logic                          O_KVS_CMD_READ,
    output logic                          O_KVS_CMD_SEARCH,
    output logic                          O_KVS_CMD_UPDATE,
    output logic [127:0]                  O_KVS_KEY_DAT,
    output logic [127:0]                  O_KVS_EKEY_MSK,
    output logic [6:0]                    O_KVS_KEY_PRI,
    output logic [31:0]                   O_KVS_KEY_VALUE,
    input  logic                          I_KVS_READY,
    input  logic                          I_KVS_WAIT,
    input  logic                          I_KVS_CMD_FULL,
    input  logic                          I_KVS_ENT_FULL,
    input  logic                          I_KVS_ACK,
    input  logic                          I_KVS_ENT_ERR,
    input  logic                          I_KVS_SINGLE_HIT,
    input  logic                          I_KVS_MULTI_HIT,
    input  logic [31:0]                   I_KVS_KEY_VALUE,
    output logic [$clog2(MAX_OUT+1)-1:0]  O_OUTSTANDING,
    output logic                          O_ABORT,
    output logic                          O_TIMEOUT,
    output logic                          O_PROTO_ERR
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1 = IDW + 1;
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] OP_ERASE  = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_SEARCH = 3'd3;
    localparam logic [2:0] OP_UPDATE = 3'd4;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDW-1:0]        r_ptr;
    logic [IDW-1:0]        r_tag_mem [MAX_OUT];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [TW-1:0]         r_to_cnt;

    logic [NUM_REQ-1:0]    w_elig;
    logic [IW1-1:0]        w_idx;
    logic                  w_hit;
    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic [NUM_REQ-1:0]    w_win_oh;
    logic [NUM_REQ-1:0]    w_head_oh;
    logic [2:0]            w_op;
    logic                  w_kern;
    logic                  w_run;
    logic                  w_flush;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_issue;
    logic                  w_reject;
    logic                  w_pop;
    logic                  w_proto;
    logic                  w_to_run;
    logic                  w_to_fire;

    // A requester granted on the previous edge still shows its old fields, so skip it once
    assign w_elig       = I_REQ_VALID & ~O_REQ_GRANT;
    assign w_fifo_full  = (r_count == CW'(MAX_OUT));
    assign w_fifo_empty = (r_count == CW'(0));
    assign w_flush      = (r_state == S_RUN) && !I_KVS_READY;
    assign w_run        = (r_state == S_RUN) && I_KVS_READY;
    assign w_op         = I_REQ_OP[int'(w_win)*3 +: 3];
    assign w_kern       = (w_op == OP_ERASE) || (w_op == OP_SEARCH) || (w_op == OP_UPDATE) ||
                          ((w_op == OP_WRITE) && !I_KVS_ENT_FULL);
    // The RR winner is never skipped: a blocked winner stalls everyone, so a reject cannot starve
    assign w_issue      = w_run && w_found && w_kern && !I_KVS_CMD_FULL && !I_KVS_WAIT &&
                          (!w_fifo_full || I_KVS_ACK);
    assign w_reject     = w_run && w_found && !w_kern && w_fifo_empty && !I_KVS_ACK;
    assign w_pop        = I_KVS_ACK && !w_fifo_empty && !w_flush;
    assign w_proto      = I_KVS_ACK && w_fifo_empty && !w_flush;
    assign w_to_run     = !w_fifo_empty && !I_KVS_ACK && !w_flush;
    assign w_to_fire    = w_to_run && (r_to_cnt == TW'(ACK_TIMEOUT - 1));
    assign w_win_oh     = NUM_REQ'(1) << w_win;
    assign w_head_oh    = NUM_REQ'(1) << r_tag_mem[r_rd_ptr];

    assign O_OUTSTANDING  = r_count;
    assign O_KVS_CMD_READ = 1'b0;

    // Round-robin search for the first eligible requester starting at the pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx   = {1'b0, r_ptr} + IW1'(k);
            w_idx   = (w_idx >= IW1'(NUM_REQ)) ? (w_idx - IW1'(NUM_REQ)) : w_idx;
            w_hit   = !w_found && w_elig[w_idx[IDW-1:0]];
            w_win   = w_hit ? w_idx[IDW-1:0] : w_win;
            w_found = w_found | w_hit;
        end
    end

    // Next-state logic: timeout is terminal, a READY drop re-enters init
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: begin
                if (w_to_fire) begin
                    w_state_nxt = S_ERR;
                end else if (I_KVS_READY && !I_KVS_WAIT) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_INIT;
                end
            end
            S_RUN: begin
                if (w_to_fire) begin
                    w_state_nxt = S_ERR;
                end else if (w_flush) begin
                    w_state_nxt = S_INIT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // State register
    always_ff @(posedge I_CLK or negedge I_XRST) begin
        if (!I_XRST) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tag FIFO, in-flight count, RR pointer, ACK timeout counter and sticky flags
    always_ff @(posedge I_CLK or negedge I_XRST) begin
        if (!I_XRST) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                r_tag_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ptr       <= '0;
            r_to_cnt    <= '0;
            O_ABORT     <= 1'b0;
            O_TIMEOUT   <= 1'b0;
            O_PROTO_ERR <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_issue) begin
                    r_tag_mem[r_wr_ptr] <= w_win;
                    r_wr_ptr            <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_issue) - CW'(w_pop);
            end
            if (w_issue || w_reject) begin
                r_ptr <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : (w_win + IDW'(1));
            end
            if (w_to_run) begin
                r_to_cnt <= (r_to_cnt == TW'(ACK_TIMEOUT)) ? r_to_cnt : (r_to_cnt + TW'(1));
            end else begin
                r_to_cnt <= '0;
            end
            O_ABORT     <= w_flush;
            O_TIMEOUT   <= O_TIMEOUT | w_to_fire;
            O_PROTO_ERR <= O_PROTO_ERR | w_proto;
        end
    end

    // Registered grant, kernel command and response outputs
    always_ff @(posedge I_CLK or negedge I_XRST) begin
        if (!I_XRST) begin
            O_REQ_GRANT      <= '0;
            O_KVS_CMD_VALID  <= 1'b0;
            O_KVS_CMD_ERASE  <= 1'b0;
            O_KVS_CMD_WRITE  <= 1'b0;
            O_KVS_CMD_SEARCH <= 1'b0;
            O_KVS_CMD_UPDATE <= 1'b0;
            O_KVS_KEY_DAT    <= '0;
            O_KVS_EKEY_MSK   <= '0;
            O_KVS_KEY_PRI    <= '0;
            O_KVS_KEY_VALUE  <= '0;
            O_RSP_VALID      <= '0;
            O_RSP_ENT_ERR    <= 1'b0;
            O_RSP_SINGLE_HIT <= 1'b0;
            O_RSP_MULTI_HIT  <= 1'b0;
            O_RSP_KEY_VALUE  <= '0;
        end else begin
            O_REQ_GRANT      <= (w_issue || w_reject) ? w_win_oh : '0;
            O_KVS_CMD_VALID  <= w_issue;
            O_KVS_CMD_ERASE  <= w_issue && (w_op == OP_ERASE);
            O_KVS_CMD_WRITE  <= w_issue && (w_op == OP_WRITE);
            O_KVS_CMD_SEARCH <= w_issue && (w_op == OP_SEARCH);
            O_KVS_CMD_UPDATE <= w_issue && (w_op == OP_UPDATE);
            if (w_issue) begin
                O_KVS_KEY_DAT   <= I_REQ_KEY_DAT[int'(w_win)*128 +: 128];
                O_KVS_EKEY_MSK  <= I_REQ_EKEY_MSK[int'(w_win)*128 +: 128];
                O_KVS_KEY_PRI   <= I_REQ_KEY_PRI[int'(w_win)*7 +: 7];
                O_KVS_KEY_VALUE <= I_REQ_KEY_VALUE[int'(w_win)*32 +: 32];
            end else begin
                O_KVS_KEY_DAT   <= '0;
                O_KVS_EKEY_MSK  <= '0;
                O_KVS_KEY_PRI   <= '0;
                O_KVS_KEY_VALUE <= '0;
            end
            // A reject needs ACK=0, so it never collides with a routed ACK
            if (w_pop) begin
                O_RSP_VALID      <= w_head_oh;
                O_RSP_ENT_ERR    <= I_KVS_ENT_ERR;
                O_RSP_SINGLE_HIT <= I_KVS_SINGLE_HIT;
                O_RSP_MULTI_HIT  <= I_KVS_MULTI_HIT;
                O_RSP_KEY_VALUE  <= I_KVS_KEY_VALUE;
            end else if (w_reject) begin
                O_RSP_VALID      <= w_win_oh;
                O_RSP_ENT_ERR    <= 1'b1;
                O_RSP_SINGLE_HIT <= 1'b0;
                O_RSP_MULTI_HIT  <= 1'b0;
                O_RSP_KEY_VALUE  <= '0;
            end else begin
                O_RSP_VALID      <= '0;
                O_RSP_ENT_ERR    <= 1'b0;
                O_RSP_SINGLE_HIT <= 1'b0;
                O_RSP_MULTI_HIT  <= 1'b0;
                O_RSP_KEY_VALUE  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axonerve_kvs_cmd_arbiter.sv
// Scoreboard bench for axonerve_kvs_cmd_arbiter: expected grants are queued
// when requests are raised, expected responses when ACKs are driven or a
// reject is granted, and both are checked as the DUT produces them.
module tb_axonerve_kvs_cmd_arbiter;

    localparam int NR = 4;
    localparam int MO = 16;
    localparam int AT = 4096;

    localparam logic [2:0] OP_ERASE  = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_SEARCH = 3'd3;
    localparam logic [2:0] OP_UPDATE = 3'd4;

    typedef struct packed {
        logic [2:0]   id;
        logic         rej;
        logic [2:0]   op;
        logic [127:0] key;
        logic [127:0] msk;
        logic [6:0]   pri;
        logic [31:0]  val;
    } gexp_t;

    typedef struct packed {
        logic [2:0]  id;
        logic        err;
        logic        sh;
        logic        mh;
        logic [31:0] val;
    } rexp_t;

    logic clk;
    logic rst_n;
    logic [NR-1:0]      I_REQ_VALID;
    logic [3*NR-1:0]    I_REQ_OP;
    logic [128*NR-1:0]  I_REQ_KEY_DAT;
    logic [128*NR-1:0]  I_REQ_EKEY_MSK;
    logic [7*NR-1:0]    I_REQ_KEY_PRI;
    logic [32*NR-1:0]   I_REQ_KEY_VALUE;
    logic [NR-1:0]      O_REQ_GRANT;
    logic [NR-1:0]      O_RSP_VALID;
    logic               O_RSP_ENT_ERR, O_RSP_SINGLE_HIT, O_RSP_MULTI_HIT;
    logic [31:0]        O_RSP_KEY_VALUE;
    logic               O_KVS_CMD_VALID, O_KVS_CMD_ERASE, O_KVS_CMD_WRITE;
    logic               O_KVS_CMD_READ, O_KVS_CMD_SEARCH, O_KVS_CMD_UPDATE;
    logic [127:0]       O_KVS_KEY_DAT, O_KVS_EKEY_MSK;
    logic [6:0]         O_KVS_KEY_PRI;
    logic [31:0]        O_KVS_KEY_VALUE;
    logic               I_KVS_READY, I_KVS_WAIT, I_KVS_CMD_FULL, I_KVS_ENT_FULL;
    logic               I_KVS_ACK, I_KVS_ENT_ERR, I_KVS_SINGLE_HIT, I_KVS_MULTI_HIT;
    logic [31:0]        I_KVS_KEY_VALUE;
    logic [4:0]         O_OUTSTANDING;
    logic               O_ABORT, O_TIMEOUT, O_PROTO_ERR;

    gexp_t       exp_grant_q[$];
    rexp_t       exp_rsp_q[$];
    logic [2:0]  tag_q[$];
    gexp_t       req_stim[NR];
    logic [31:0] seq;
    int          checks;
    int          errors;

    axonerve_kvs_cmd_arbiter #(.NUM_REQ(NR), .MAX_OUT(MO), .ACK_TIMEOUT(AT)) dut (
        .I_CLK(clk), .I_XRST(rst_n),
        .I_REQ_VALID(I_REQ_VALID), .I_REQ_OP(I_REQ_OP),
        .I_REQ_KEY_DAT(I_REQ_KEY_DAT), .I_REQ_EKEY_MSK(I_REQ_EKEY_MSK),
        .I_REQ_KEY_PRI(I_REQ_KEY_PRI), .I_REQ_KEY_VALUE(I_REQ_KEY_VALUE),
        .O_REQ_GRANT(O_REQ_GRANT), .O_RSP_VALID(O_RSP_VALID),
        .O_RSP_ENT_ERR(O_RSP_ENT_ERR), .O_RSP_SINGLE_HIT(O_RSP_SINGLE_HIT),
        .O_RSP_MULTI_HIT(O_RSP_MULTI_HIT), .O_RSP_KEY_VALUE(O_RSP_KEY_VALUE),
        .O_KVS_CMD_VALID(O_KVS_CMD_VALID), .O_KVS_CMD_ERASE(O_KVS_CMD_ERASE),
        .O_KVS_CMD_WRITE(O_KVS_CMD_WRITE), .O_KVS_CMD_READ(O_KVS_CMD_READ),
        .O_KVS_CMD_SEARCH(O_KVS_CMD_SEARCH), .O_KVS_CMD_UPDATE(O_KVS_CMD_UPDATE),
        .O_KVS_KEY_DAT(O_KVS_KEY_DAT), .O_KVS_EKEY_MSK(O_KVS_EKEY_MSK),
        .O_KVS_KEY_PRI(O_KVS_KEY_PRI), .O_KVS_KEY_VALUE(O_KVS_KEY_VALUE),
        .I_KVS_READY(I_KVS_READY), .I_KVS_WAIT(I_KVS_WAIT),
        .I_KVS_CMD_FULL(I_KVS_CMD_FULL), .I_KVS_ENT_FULL(I_KVS_ENT_FULL),
        .I_KVS_ACK(I_KVS_ACK), .I_KVS_ENT_ERR(I_KVS_ENT_ERR),
        .I_KVS_SINGLE_HIT(I_KVS_SINGLE_HIT), .I_KVS_MULTI_HIT(I_KVS_MULTI_HIT),
        .I_KVS_KEY_VALUE(I_KVS_KEY_VALUE),
        .O_OUTSTANDING(O_OUTSTANDING), .O_ABORT(O_ABORT),
        .O_TIMEOUT(O_TIMEOUT), .O_PROTO_ERR(O_PROTO_ERR)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise a request; the expected grant (issue or local reject) is decided here
    task automatic set_req(input int id, input logic [2:0] op, input bit push);
        gexp_t g;
        seq   = seq + 32'd1;
        g.id  = 3'(id);
        g.op  = op;
        g.key = {seq, ~seq, seq ^ 32'h5A5A_5A5A, 32'(id)};
        g.msk = {4{seq ^ 32'hFFFF_0000}};
        g.pri = seq[6:0];
        g.val = seq * 32'd7;
        g.rej = !((op == OP_ERASE) || (op == OP_SEARCH) || (op == OP_UPDATE) ||
                  ((op == OP_WRITE) && !I_KVS_ENT_FULL));
        I_REQ_OP[id*3 +: 3]          = op;
        I_REQ_KEY_DAT[id*128 +: 128]  = g.key;
        I_REQ_EKEY_MSK[id*128 +: 128] = g.msk;
        I_REQ_KEY_PRI[id*7 +: 7]      = g.pri;
        I_REQ_KEY_VALUE[id*32 +: 32]  = g.val;
        I_REQ_VALID[id]               = 1'b1;
        req_stim[id]                  = g;
        if (push) exp_grant_q.push_back(g);
    endtask

    // Advance one cycle, then score any grant/command and any response
    task automatic tick();
        gexp_t      g;
        rexp_t      r;
        logic [3:0] oh;
        @(posedge clk);
        #1;
        checks++;
        if (O_REQ_GRANT !== 4'b0000) begin
            if (exp_grant_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected got=%b exp=0000", O_REQ_GRANT);
            end else begin
                g  = exp_grant_q.pop_front();
                oh = 4'b0001 << g.id;
                if (O_REQ_GRANT !== oh) begin
                    errors++;
                    $display("FAIL grant_id got=%b exp=%b", O_REQ_GRANT, oh);
                end
                checks++;
                if (g.rej) begin
                    if (O_KVS_CMD_VALID !== 1'b0) begin
                        errors++;
                        $display("FAIL reject_cmd got=%b exp=0", O_KVS_CMD_VALID);
                    end
                    r.id = g.id; r.err = 1'b1; r.sh = 1'b0; r.mh = 1'b0; r.val = 32'd0;
                    exp_rsp_q.push_back(r);
                end else begin
                    if ({O_KVS_CMD_VALID, O_KVS_CMD_ERASE, O_KVS_CMD_WRITE, O_KVS_CMD_SEARCH,
                         O_KVS_CMD_UPDATE, O_KVS_CMD_READ} !==
                        {1'b1, g.op == OP_ERASE, g.op == OP_WRITE, g.op == OP_SEARCH,
                         g.op == OP_UPDATE, 1'b0} ||
                        O_KVS_KEY_DAT !== g.key || O_KVS_EKEY_MSK !== g.msk ||
                        O_KVS_KEY_PRI !== g.pri || O_KVS_KEY_VALUE !== g.val) begin
                        errors++;
                        $display("FAIL cmd_fields id=%0d got op=%b%b%b%b key=%h val=%h exp op=%0d key=%h val=%h",
                                 g.id, O_KVS_CMD_ERASE, O_KVS_CMD_WRITE, O_KVS_CMD_SEARCH,
                                 O_KVS_CMD_UPDATE, O_KVS_KEY_DAT, O_KVS_KEY_VALUE, g.op, g.key, g.val);
                    end
                    tag_q.push_back(g.id);
                end
            end
            I_REQ_VALID = I_REQ_VALID & ~O_REQ_GRANT;
        end else if (O_KVS_CMD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL cmd_idle got=%b exp=0", O_KVS_CMD_VALID);
        end
        if (O_RSP_VALID !== 4'b0000) begin
            checks++;
            if (exp_rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got=%b exp=0000", O_RSP_VALID);
            end else begin
                r  = exp_rsp_q.pop_front();
                oh = 4'b0001 << r.id;
                if (O_RSP_VALID !== oh || O_RSP_ENT_ERR !== r.err || O_RSP_SINGLE_HIT !== r.sh ||
                    O_RSP_MULTI_HIT !== r.mh || O_RSP_KEY_VALUE !== r.val) begin
                    errors++;
                    $display("FAIL rsp got=%b err=%b sh=%b mh=%b val=%h exp=%b err=%b sh=%b mh=%b val=%h",
                             O_RSP_VALID, O_RSP_ENT_ERR, O_RSP_SINGLE_HIT, O_RSP_MULTI_HIT,
                             O_RSP_KEY_VALUE, oh, r.err, r.sh, r.mh, r.val);
                end
            end
        end
    endtask

    // One-cycle kernel ACK; the bench's own tag model names the owner
    task automatic ack_pulse(input logic err, input logic sh, input logic mh, input logic [31:0] val);
        rexp_t r;
        I_KVS_ACK = 1'b1; I_KVS_ENT_ERR = err; I_KVS_SINGLE_HIT = sh;
        I_KVS_MULTI_HIT = mh; I_KVS_KEY_VALUE = val;
        if (tag_q.size() != 0) begin
            r.id = tag_q.pop_front(); r.err = err; r.sh = sh; r.mh = mh; r.val = val;
            exp_rsp_q.push_back(r);
        end
        tick();
        I_KVS_ACK = 1'b0; I_KVS_ENT_ERR = 1'b0; I_KVS_SINGLE_HIT = 1'b0;
        I_KVS_MULTI_HIT = 1'b0; I_KVS_KEY_VALUE = 32'd0;
    endtask

    // Tick until every queued grant has appeared, bounded
    task automatic wait_grants(input int budget, input string name);
        int n;
        n = 0;
        while (exp_grant_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_grant_q.size() != 0) begin
            errors++;
            $display("FAIL %s_grant_wait pending=%0d exp=0", name, exp_grant_q.size());
            exp_grant_q.delete();
        end
    endtask

    task automatic check_count(input logic [4:0] exp, input string name);
        checks++;
        if (O_OUTSTANDING !== exp) begin
            errors++;
            $display("FAIL %s_outstanding got=%0d exp=%0d", name, O_OUTSTANDING, exp);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_rsp_q.size() != 0 || exp_grant_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got rsp=%0d grant=%0d exp=0", name, exp_rsp_q.size(), exp_grant_q.size());
        end
        exp_rsp_q.delete();
        exp_grant_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        I_REQ_VALID = '0; I_REQ_OP = '0; I_REQ_KEY_DAT = '0; I_REQ_EKEY_MSK = '0;
        I_REQ_KEY_PRI = '0; I_REQ_KEY_VALUE = '0;
        I_KVS_READY = 1'b0; I_KVS_WAIT = 1'b0; I_KVS_CMD_FULL = 1'b0; I_KVS_ENT_FULL = 1'b0;
        I_KVS_ACK = 1'b0; I_KVS_ENT_ERR = 1'b0; I_KVS_SINGLE_HIT = 1'b0; I_KVS_MULTI_HIT = 1'b0;
        I_KVS_KEY_VALUE = 32'd0;
        exp_grant_q.delete(); exp_rsp_q.delete(); tag_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({O_REQ_GRANT, O_RSP_VALID, O_KVS_CMD_VALID, O_OUTSTANDING, O_ABORT, O_TIMEOUT,
             O_PROTO_ERR, O_RSP_KEY_VALUE, O_KVS_KEY_DAT} !== '0) begin
            errors++;
            $display("FAIL reset_state got grant=%b rsp=%b cmd=%b out=%0d abort=%b to=%b perr=%b exp all 0",
                     O_REQ_GRANT, O_RSP_VALID, O_KVS_CMD_VALID, O_OUTSTANDING, O_ABORT, O_TIMEOUT, O_PROTO_ERR);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int n;
        for (int i = 0; i < NR; i++) set_req(i, OP_SEARCH, 1'b1);
        repeat (4) tick();   // READY low: held in init, no grant may appear
        I_KVS_READY = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && exp_grant_q.size() != 0; c++) begin
            tick();
            if (O_REQ_GRANT !== 4'b0000) begin
                n++;
                checks++;
                if (O_OUTSTANDING !== 5'(n)) begin
                    errors++;
                    $display("FAIL rr_outstanding got=%0d exp=%0d", O_OUTSTANDING, n);
                end
            end
        end
        wait_grants(1, "rr");
        check_count(5'd4, "rr_final");
    endtask

    task automatic test_ack_routing();
        ack_pulse(1'b0, 1'b1, 1'b0, 32'hA);
        check_count(5'd3, "ack1");
        ack_pulse(1'b0, 1'b0, 1'b1, 32'hB);
        ack_pulse(1'b1, 1'b0, 1'b0, 32'hC);
        ack_pulse(1'b0, 1'b1, 1'b1, 32'hD);
        check_count(5'd0, "ack4");
        check_drained("ack");
    endtask

    task automatic test_reject_drain();
        set_req(0, OP_SEARCH, 1'b1);
        set_req(2, OP_SEARCH, 1'b1);
        set_req(3, OP_SEARCH, 1'b1);
        wait_grants(10, "rej_fill");
        set_req(1, OP_READ, 1'b1);
        set_req(2, OP_SEARCH, 1'b1);
        repeat (5) tick();
        check_count(5'd3, "rej_stall");
        checks++;
        if (exp_grant_q.size() != 2) begin
            errors++;
            $display("FAIL rej_stall_grants got=%0d pending exp=2", exp_grant_q.size());
        end
        ack_pulse(1'b0, 1'b0, 1'b0, 32'h11);
        ack_pulse(1'b0, 1'b0, 1'b0, 32'h22);
        ack_pulse(1'b0, 1'b0, 1'b0, 32'h33);
        tick();
        checks++;
        if (O_REQ_GRANT !== 4'b0010 || O_RSP_VALID !== 4'b0010 || O_RSP_ENT_ERR !== 1'b1) begin
            errors++;
            $display("FAIL rej_timing got grant=%b rsp=%b err=%b exp 0010 0010 1",
                     O_REQ_GRANT, O_RSP_VALID, O_RSP_ENT_ERR);
        end
        wait_grants(5, "rej_after");
        ack_pulse(1'b0, 1'b1, 1'b0, 32'h44);
        check_drained("rej");
    endtask

    task automatic test_fifo_full();
        logic [2:0] ops [4];
        ops[0] = OP_SEARCH; ops[1] = OP_WRITE; ops[2] = OP_ERASE; ops[3] = OP_UPDATE;
        for (int k = 0; k < MO; k++) begin
            set_req((3 + k) % NR, ops[k % 4], 1'b1);
            wait_grants(10, "full_fill");
        end
        check_count(5'd16, "full");
        set_req(2, OP_SEARCH, 1'b0);
        repeat (4) tick();
        check_count(5'd16, "full_blocked");
        exp_grant_q.push_back(req_stim[2]);
        ack_pulse(1'b0, 1'b1, 1'b0, 32'hF00D);
        check_count(5'd16, "full_ack_issue");
        wait_grants(1, "full_swap");
        for (int k = 0; k < MO; k++) ack_pulse(1'b0, 1'b0, 1'b0, 32'(k));
        check_count(5'd0, "full_drain");
        check_drained("full");
    endtask

    task automatic test_reject_misc();
        I_KVS_ENT_FULL = 1'b1;
        set_req(3, OP_WRITE, 1'b1);
        wait_grants(5, "wr_full");
        tick();
        set_req(0, 3'd7, 1'b1);
        wait_grants(5, "illegal");
        I_KVS_ENT_FULL = 1'b0;
        tick();
        I_KVS_CMD_FULL = 1'b1;
        set_req(1, OP_WRITE, 1'b0);
        repeat (3) tick();
        check_count(5'd0, "cmd_full_hold");
        I_KVS_CMD_FULL = 1'b0;
        exp_grant_q.push_back(req_stim[1]);
        wait_grants(5, "cmd_full_release");
        ack_pulse(1'b0, 1'b0, 1'b0, 32'h77);
        check_drained("misc");
    endtask

    task automatic test_proto_timeout();
        ack_pulse(1'b0, 1'b1, 1'b0, 32'hBAD);
        checks++;
        if (O_PROTO_ERR !== 1'b1 || O_RSP_VALID !== 4'b0000) begin
            errors++;
            $display("FAIL proto_err got perr=%b rsp=%b exp 1 0000", O_PROTO_ERR, O_RSP_VALID);
        end
        repeat (2) tick();
        checks++;
        if (O_PROTO_ERR !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky got=%b exp=1", O_PROTO_ERR);
        end
        set_req(2, OP_SEARCH, 1'b1);
        wait_grants(5, "to_issue");
        repeat (AT - 1) tick();
        checks++;
        if (O_TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got=%b exp=0", O_TIMEOUT);
        end
        tick();
        checks++;
        if (O_TIMEOUT !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire got=%b exp=1", O_TIMEOUT);
        end
        set_req(1, OP_SEARCH, 1'b0);
        repeat (5) tick();
        ack_pulse(1'b0, 1'b0, 1'b1, 32'hE44);
        checks++;
        if (O_TIMEOUT !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b exp=1", O_TIMEOUT);
        end
        I_REQ_VALID[1] = 1'b0;
        check_drained("timeout");
    endtask

    task automatic test_abort();
        I_KVS_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(k % NR, OP_SEARCH, 1'b1);
            wait_grants(10, "abort_fill");
        end
        check_count(5'd5, "abort_fill");
        I_KVS_READY = 1'b0;
        tick();
        checks++;
        if (O_ABORT !== 1'b1 || O_OUTSTANDING !== 5'd0) begin
            errors++;
            $display("FAIL abort_pulse got abort=%b out=%0d exp 1 0", O_ABORT, O_OUTSTANDING);
        end
        tag_q.delete();
        tick();
        checks++;
        if (O_ABORT !== 1'b0) begin
            errors++;
            $display("FAIL abort_width got=%b exp=0", O_ABORT);
        end
        ack_pulse(1'b0, 1'b0, 1'b0, 32'h1);
        I_KVS_READY = 1'b1;
        set_req(1, OP_SEARCH, 1'b1);
        wait_grants(10, "abort_resume");
        check_count(5'd1, "abort_resume");
        check_drained("abort");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (O_OUTSTANDING !== 5'd0 || O_PROTO_ERR !== 1'b0 || O_REQ_GRANT !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got out=%0d perr=%b grant=%b exp 0 0 0000",
                     O_OUTSTANDING, O_PROTO_ERR, O_REQ_GRANT);
        end
        tag_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Test sequence
    initial begin
        checks = 0;
        errors = 0;
        seq    = 32'h100;
        rst_n  = 1'b0;
        test_reset();
        test_round_robin();
        test_ack_routing();
        test_reject_drain();
        test_fifo_full();
        test_reject_misc();
        test_proto_timeout();
        test_reset();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
